// File: rtl/sim_harness_pkg.sv
// -----------------------------------------------------------------------------
// sim_harness_pkg
// Shared types and helpers for the simulation stream harness.
//   state_e   : harness FSM states (WAIT -> RUN -> PASS | TIMEOUT)
//   sat_inc32 : 32-bit saturating increment used by every harness counter
// -----------------------------------------------------------------------------
package sim_harness_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PASS    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage : sim_harness_pkg

// File: rtl/sim_stream_harness_if.sv
// -----------------------------------------------------------------------------
// sim_stream_harness_if
// Valid/ready/data stream bundle used for the harness stimulus, SoC-input (tx)
// and SoC-output (rx) streams.
//   master : drives valid/data, samples ready
//   slave  : samples valid/data, drives ready
// -----------------------------------------------------------------------------
interface sim_stream_harness_if #(
    parameter int unsigned W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface : sim_stream_harness_if

// File: rtl/sim_fifo.sv
// -----------------------------------------------------------------------------
// sim_fifo
// W x DEPTH synchronous FIFO, valid/ready on both sides. Full/empty come from
// read/write pointers carrying one extra wrap bit. No write-to-read bypass:
// a word pushed at edge n is visible at out_data from cycle n+1.
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready     : push side (in_ready = not full)
//   in_data               : word to push
//   out_valid/out_ready   : pop side (out_valid = not empty)
//   out_data              : head of FIFO
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module sim_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

    // Handshakes use registered full/empty, so a push into a full FIFO is
    // refused even when a pop happens in the same cycle.
    assign push = in_valid  & ~full;
    assign pop  = out_ready & ~empty;

    always_comb begin
        // NOTE: every variable gets its default before any condition so that
        // no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of the order the always blocks are evaluated in.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and a resettable array would cost a flop-based memory.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end

endmodule : sim_fifo

// File: rtl/sim_stream_harness.sv
// -----------------------------------------------------------------------------
// sim_stream_harness
// Harness between the simulation toplevel and the SoC byte-stream console.
// Host stimulus is buffered in a FIFO and offered to the SoC input stream once
// the harness is running; SoC output words are captured for logging. The test
// ends as a pass on END_CODE or as a failure after TIMEOUT idle cycles.
//   clock, reset_n   : clock, asynchronous active-low reset
//   stim (slave)     : host stimulus push; ready = FIFO not full
//   tx   (master)    : FIFO head towards the SoC input, valid only in RUN
//   rx   (slave)     : SoC output words; ready in RUN with optional stalls
//   cap_valid/data   : registered one-cycle pulse per captured word
//   done / passed    : sticky end-of-test flags
//   rx_count         : captured words (saturating)
//   cycle_count      : cycles since reset release, frozen once done
// WAIT lasts START_DELAY+1 cycles, so the first RUN cycle follows clock edge
// START_DELAY+1 after reset release.
// -----------------------------------------------------------------------------
module sim_stream_harness
    import sim_harness_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned START_DELAY = 4,
    parameter int unsigned TIMEOUT     = 1000,
    parameter logic [31:0] END_CODE    = 32'h04,
    parameter int unsigned RX_STALL    = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sim_stream_harness_if.slave  stim,
    sim_stream_harness_if.master tx,
    sim_stream_harness_if.slave  rx,
    output logic                 cap_valid,
    output logic [W-1:0]         cap_data,
    output logic                 done,
    output logic                 passed,
    output logic [31:0]          rx_count,
    output logic [31:0]          cycle_count
);

    // Last phase of the stall counter; the cycle in which rx_ready drops.
    localparam logic [31:0] STALL_LAST = (RX_STALL == 0) ? 32'd0 : 32'(RX_STALL - 1);

    state_e       state_q, state_d;
    logic [31:0]  delay_q, delay_d;
    logic [31:0]  idle_q, idle_d;
    logic [31:0]  stall_q, stall_d;
    logic [31:0]  rx_count_q, rx_count_d;
    logic [31:0]  cycle_q, cycle_d;
    logic         cap_valid_q, cap_valid_d;
    logic [W-1:0] cap_data_q, cap_data_d;

    logic         run;
    logic         finished;
    logic         fifo_valid;
    logic         tx_fire;
    logic         rx_fire;
    logic         end_hit;
    logic         idle_hit;
    logic         stall_hit;

    // ---------------------------------------------------------------- FIFO
    // Pushes are accepted in every state; pops only while running.
    sim_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (stim.valid),
        .in_ready  (stim.ready),
        .in_data   (stim.data),
        .out_valid (fifo_valid),
        .out_ready (run & tx.ready),
        .out_data  (tx.data)
    );

    // ---------------------------------------------------- stream handshakes
    // tx.valid and rx.ready depend on registered state only.
    assign run       = (state_q == ST_RUN);
    assign finished  = (state_q == ST_PASS) || (state_q == ST_TIMEOUT);
    assign stall_hit = (RX_STALL != 0) && (stall_q == STALL_LAST);

    assign tx.valid = run & fifo_valid;
    assign rx.ready = run & ~stall_hit;

    assign tx_fire  = tx.valid & tx.ready;
    assign rx_fire  = rx.valid & rx.ready;
    assign end_hit  = rx_fire && (rx.data == END_CODE[W-1:0]);
    assign idle_hit = (TIMEOUT != 0) && (idle_q >= TIMEOUT);

    // ------------------------------------------------ FSM and counters
    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        idle_d      = '0;
        stall_d     = '0;
        rx_count_d  = rx_count_q;
        cycle_d     = cycle_q;
        cap_valid_d = rx_fire;
        cap_data_d  = cap_data_q;

        unique case (state_q)
            ST_WAIT: begin
                if (delay_q >= START_DELAY) state_d = ST_RUN;
                else                        delay_d = sat_inc32(delay_q);
            end
            ST_RUN: begin
                // The end code outranks a watchdog expiry in the same cycle.
                if      (end_hit)  state_d = ST_PASS;
                else if (idle_hit) state_d = ST_TIMEOUT;
            end
            default: ;  // PASS and TIMEOUT hold until reset
        endcase

        // The watchdog and stall phase only advance while running.
        if (run) begin
            idle_d = (tx_fire || rx_fire) ? 32'd0 : sat_inc32(idle_q);
            if (RX_STALL != 0) stall_d = (stall_q == STALL_LAST) ? 32'd0 : stall_q + 32'd1;
        end

        if (rx_fire) begin
            rx_count_d = sat_inc32(rx_count_q);
            cap_data_d = rx.data;
        end

        if (!finished) cycle_d = sat_inc32(cycle_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT;
            delay_q     <= '0;
            idle_q      <= '0;
            stall_q     <= '0;
            rx_count_q  <= '0;
            cycle_q     <= '0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            idle_q      <= idle_d;
            stall_q     <= stall_d;
            rx_count_q  <= rx_count_d;
            cycle_q     <= cycle_d;
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
        end
    end

    // ---------------------------------------------------------- outputs
    assign cap_valid   = cap_valid_q;
    assign cap_data    = cap_data_q;
    assign done        = finished;
    assign passed      = (state_q == ST_PASS);
    assign rx_count    = rx_count_q;
    assign cycle_count = cycle_q;

endmodule : sim_stream_harness

// File: tb/tb_sim_stream_harness.sv
// -----------------------------------------------------------------------------
// tb_sim_stream_harness
// Directed bench for sim_stream_harness. Two instances share clock and reset:
//   dut_a : START_DELAY=4, TIMEOUT=20, no rx stalls
//   dut_b : START_DELAY=4, TIMEOUT disabled, RX_STALL=3
// Inputs are driven 1 time unit after the rising edge; outputs, which depend
// on registered state only, are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sim_stream_harness;

    logic clock;
    logic reset_n;

    int n_tests = 0;
    int n_fail  = 0;

    sim_stream_harness_if #(.W(8)) a_stim ();
    sim_stream_harness_if #(.W(8)) a_tx ();
    sim_stream_harness_if #(.W(8)) a_rx ();
    sim_stream_harness_if #(.W(8)) b_stim ();
    sim_stream_harness_if #(.W(8)) b_tx ();
    sim_stream_harness_if #(.W(8)) b_rx ();

    logic        a_cap_valid, b_cap_valid;
    logic [7:0]  a_cap_data,  b_cap_data;
    logic        a_done,      b_done;
    logic        a_passed,    b_passed;
    logic [31:0] a_rx_count,  b_rx_count;
    logic [31:0] a_cycles,    b_cycles;

    sim_stream_harness #(
        .W(8), .DEPTH(16), .START_DELAY(4), .TIMEOUT(20), .END_CODE(32'h04), .RX_STALL(0)
    ) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .stim        (a_stim),
        .tx          (a_tx),
        .rx          (a_rx),
        .cap_valid   (a_cap_valid),
        .cap_data    (a_cap_data),
        .done        (a_done),
        .passed      (a_passed),
        .rx_count    (a_rx_count),
        .cycle_count (a_cycles)
    );

    sim_stream_harness #(
        .W(8), .DEPTH(16), .START_DELAY(4), .TIMEOUT(0), .END_CODE(32'h04), .RX_STALL(3)
    ) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .stim        (b_stim),
        .tx          (b_tx),
        .rx          (b_rx),
        .cap_valid   (b_cap_valid),
        .cap_data    (b_cap_data),
        .done        (b_done),
        .passed      (b_passed),
        .rx_count    (b_rx_count),
        .cycle_count (b_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench in "cycle 0": reset released, no clock edge seen yet.
    task automatic do_reset();
        a_stim.valid = 1'b0; a_stim.data = 8'h00;
        a_tx.ready   = 1'b0;
        a_rx.valid   = 1'b0; a_rx.data   = 8'h00;
        b_stim.valid = 1'b0; b_stim.data = 8'h00;
        b_tx.ready   = 1'b0;
        b_rx.valid   = 1'b0; b_rx.data   = 8'h00;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int idx;
        logic fire;

        reset_n = 1'b0;
        do_reset();

        // ---------------------------------------------------- reset state
        check("rst_tx_valid",   32'(a_tx.valid),   32'd0);
        check("rst_stim_ready", 32'(a_stim.ready), 32'd1);
        check("rst_rx_ready",   32'(a_rx.ready),   32'd0);
        check("rst_cap_valid",  32'(a_cap_valid),  32'd0);
        check("rst_cap_data",   32'(a_cap_data),   32'd0);
        check("rst_done",       32'(a_done),       32'd0);
        check("rst_passed",     32'(a_passed),     32'd0);
        check("rst_rx_count",   a_rx_count,        32'd0);
        check("rst_cycles",     a_cycles,          32'd0);

        // ------------------------------ stimulus pushed during WAIT drains in RUN
        a_tx.ready   = 1'b1;
        a_stim.valid = 1'b1;
        a_stim.data  = 8'h41; tick();
        a_stim.data  = 8'h42; tick();
        a_stim.data  = 8'h43; tick();
        a_stim.valid = 1'b0;
        check("wait_no_tx", 32'(a_tx.valid), 32'd0);
        tick(); tick();                               // edge 5: first RUN cycle
        check("run_entry_cycles", a_cycles, 32'd5);
        check("tx0_valid", 32'(a_tx.valid), 32'd1);
        check("tx0_data",  32'(a_tx.data),  32'h41);
        tick();
        check("tx1_data",  32'(a_tx.data),  32'h42);
        tick();
        check("tx2_data",  32'(a_tx.data),  32'h43);
        tick();
        check("tx_drained", 32'(a_tx.valid), 32'd0);

        // ------------------------------------ capture and end-code pass
        a_rx.valid = 1'b1;
        a_rx.data  = 8'h48;
        check("rx_ready_run", 32'(a_rx.ready), 32'd1);
        tick();
        check("cap0_valid", 32'(a_cap_valid), 32'd1);
        check("cap0_data",  32'(a_cap_data),  32'h48);
        check("cap0_count", a_rx_count,       32'd1);
        a_rx.data = 8'h69;
        tick();
        check("cap1_data",  32'(a_cap_data),  32'h69);
        check("cap1_count", a_rx_count,       32'd2);
        check("cap1_done",  32'(a_done),      32'd0);
        a_rx.data = 8'h04;
        tick();                                       // edge 11
        a_rx.valid = 1'b0;
        check("cap2_data",   32'(a_cap_data), 32'h04);
        check("cap2_count",  a_rx_count,      32'd3);
        check("pass_passed", 32'(a_passed),   32'd1);
        check("pass_done",   32'(a_done),     32'd1);
        check("pass_rx_rdy", 32'(a_rx.ready), 32'd0);
        check("pass_cycles", a_cycles,        32'd11);
        tick();
        check("pass_cap_pulse", 32'(a_cap_valid), 32'd0);
        tick();
        check("pass_cycles_frozen", a_cycles, 32'd11);

        // ------------------------------------------------ idle watchdog
        do_reset();
        repeat (25) tick();
        check("to_before", 32'(a_done), 32'd0);
        tick();                                       // edge 26 = RUN entry + 21
        check("to_done",     32'(a_done),     32'd1);
        check("to_passed",   32'(a_passed),   32'd0);
        check("to_cycles",   a_cycles,        32'd26);
        check("to_rx_ready", 32'(a_rx.ready), 32'd0);
        repeat (3) tick();
        check("to_cycles_frozen", a_cycles, 32'd26);

        // ---------------------------------------------- reset mid-stream
        do_reset();
        a_stim.valid = 1'b1;
        a_stim.data  = 8'h51; tick();
        a_stim.data  = 8'h52; tick();
        a_stim.valid = 1'b0;
        repeat (3) tick();                            // edge 5: RUN, tx_ready low
        check("mr_tx_valid", 32'(a_tx.valid), 32'd1);
        a_rx.valid = 1'b1;
        a_rx.data  = 8'h33;
        tick();
        a_rx.valid = 1'b0;
        check("mr_cap_before", 32'(a_cap_valid), 32'd1);
        #2;
        reset_n = 1'b0;                               // between clock edges
        #1;
        check("mr_tx_valid_rst",   32'(a_tx.valid),   32'd0);
        check("mr_stim_ready_rst", 32'(a_stim.ready), 32'd1);
        check("mr_rx_ready_rst",   32'(a_rx.ready),   32'd0);
        check("mr_cap_valid_rst",  32'(a_cap_valid),  32'd0);
        check("mr_cap_data_rst",   32'(a_cap_data),   32'd0);
        check("mr_rx_count_rst",   a_rx_count,        32'd0);
        check("mr_cycles_rst",     a_cycles,          32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (4) tick();
        check("mr_still_wait", 32'(a_rx.ready), 32'd0);
        tick();
        check("mr_run_again",  32'(a_rx.ready), 32'd1);
        check("mr_fifo_empty", 32'(a_tx.valid), 32'd0);

        // -------------------------------------- rx backpressure, RX_STALL=3
        do_reset();
        b_rx.valid = 1'b1;
        b_rx.data  = 8'h10;
        repeat (5) tick();                            // first RUN cycle
        idx = 0;
        for (int k = 0; k < 13; k++) begin
            fire = (k % 3) != 2;
            check($sformatf("stall_rdy_%0d", k), 32'(b_rx.ready), 32'(fire));
            tick();
            if (fire) begin
                check($sformatf("stall_cap_%0d", idx), 32'(b_cap_data), 32'h10 + 32'(idx));
                idx++;
                b_rx.data = 8'h10 + 8'(idx);
            end else begin
                check($sformatf("stall_nocap_%0d", k), 32'(b_cap_valid), 32'd0);
            end
        end
        b_rx.valid = 1'b0;
        check("stall_rx_count", b_rx_count, 32'd9);
        check("stall_not_done", 32'(b_done), 32'd0);

        // ---------------------------------------------- FIFO full behaviour
        do_reset();
        b_stim.valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_stim.data = 8'hA0 + 8'(i);
            check($sformatf("fill_ready_%0d", i), 32'(b_stim.ready), 32'd1);
            tick();
        end
        check("full_not_ready", 32'(b_stim.ready), 32'd0);
        b_stim.data = 8'hEE;                          // dropped: FIFO full
        tick();
        b_stim.data = 8'hDD;                          // refused: pop in same cycle
        b_tx.ready  = 1'b1;
        check("full_head_valid", 32'(b_tx.valid), 32'd1);
        check("full_head_data",  32'(b_tx.data),  32'hA0);
        tick();
        b_stim.valid = 1'b0;
        b_tx.ready   = 1'b0;
        check("popped_ready", 32'(b_stim.ready), 32'd1);
        tick();
        check("popped_ready_hold", 32'(b_stim.ready), 32'd1);
        b_tx.ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(b_tx.valid), 32'd1);
            check($sformatf("drain_data_%0d", i),  32'(b_tx.data),  32'hA0 + 32'(i));
            tick();
        end
        check("drain_empty", 32'(b_tx.valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sim_stream_harness
